// File: rtl/rgb_dither_pkg.sv
// Shared constants for the RGB dither output stage.
// Bayer 2x2 thresholds, channel widths and saturation limit.
package rgb_dither_pkg;

  localparam int IN_W  = 6;
  localparam int OUT_W = 3;

  localparam logic [IN_W:0] SAT_LIM = 7'd63;

  localparam logic [2:0] BAYER_00 = 3'd0;
  localparam logic [2:0] BAYER_01 = 3'd4;
  localparam logic [2:0] BAYER_10 = 3'd6;
  localparam logic [2:0] BAYER_11 = 3'd2;

  function automatic logic [2:0] bayer_t(
    input logic y,
    input logic x
  );
    logic [2:0] t;
    case ({y, x})
      2'b00:   t = BAYER_00;
      2'b01:   t = BAYER_01;
      2'b10:   t = BAYER_10;
      default: t = BAYER_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rgb_dither_out_ch.sv
// dither_ch: one colour channel of the second pipeline stage.
// Ports: c_i colour, t_i threshold, blank_i, c_o 3-bit result.
module dither_ch
  import rgb_dither_pkg::*;
(
  input  logic [IN_W-1:0]  c_i,
  input  logic [2:0]       t_i,
  input  logic             blank_i,
  output logic [OUT_W-1:0] c_o
);

  logic [IN_W:0] s;

  always_comb begin
    s   = {1'b0, c_i} + {{(IN_W-2){1'b0}}, t_i};
    c_o = s[IN_W-1:IN_W-OUT_W];
    // Clamp instead of letting bit 6 wrap the top bits.
    if (s > SAT_LIM) c_o = '1;
    if (blank_i)     c_o = '0;
  end

endmodule

// File: rtl/rgb_dither_out.sv
// 6-bit to 3-bit RGB output stage with 2x2 ordered dither.
// Ports: clk_vga, reset, pix_ce, rgb/blank/sync in, 3-bit rgb and syncs out.
module rgb_dither_out
  import rgb_dither_pkg::*;
#(
  parameter bit HSYNC_ACT_LOW = 1'b1,
  parameter bit VSYNC_ACT_LOW = 1'b1,
  parameter bit TEMPORAL      = 1'b1
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             blank_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             dither_en,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  localparam logic HS_IDLE = HSYNC_ACT_LOW;
  localparam logic VS_IDLE = VSYNC_ACT_LOW;

  logic hs_q, hs_d, vs_q, vs_d;
  logic xp_q, xp_d, yp_q, yp_d;
  logic fp_q, fp_d;

  logic [IN_W-1:0] r1_q, r1_d;
  logic [IN_W-1:0] g1_q, g1_d;
  logic [IN_W-1:0] b1_q, b1_d;
  logic            bl1_q, bl1_d;
  logic            hs1_q, hs1_d;
  logic            vs1_q, vs1_d;
  logic [2:0]      t1_q, t1_d;

  logic [OUT_W-1:0] r2_q, r2_d;
  logic [OUT_W-1:0] g2_q, g2_d;
  logic [OUT_W-1:0] b2_q, b2_d;
  logic             hs2_q, hs2_d;
  logic             vs2_q, vs2_d;

  logic [OUT_W-1:0] r_dit, g_dit, b_dit;
  logic hs_edge, vs_edge;

  // Active-going edge: input active now, registered copy was idle.
  assign hs_edge = (hsync_in ^ HS_IDLE) & ~(hs_q ^ HS_IDLE);
  assign vs_edge = (vsync_in ^ VS_IDLE) & ~(vs_q ^ VS_IDLE);

  dither_ch u_r (
    .c_i(r1_q), .t_i(t1_q), .blank_i(bl1_q), .c_o(r_dit)
  );
  dither_ch u_g (
    .c_i(g1_q), .t_i(t1_q), .blank_i(bl1_q), .c_o(g_dit)
  );
  dither_ch u_b (
    .c_i(b1_q), .t_i(t1_q), .blank_i(bl1_q), .c_o(b_dit)
  );

  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    xp_d  = xp_q;
    yp_d  = yp_q;
    fp_d  = fp_q;
    r1_d  = r1_q;
    g1_d  = g1_q;
    b1_d  = b1_q;
    bl1_d = bl1_q;
    hs1_d = hs1_q;
    vs1_d = vs1_q;
    t1_d  = t1_q;
    r2_d  = r2_q;
    g2_d  = g2_q;
    b2_d  = b2_q;
    hs2_d = hs2_q;
    vs2_d = vs2_q;
    if (pix_ce) begin
      hs_d  = hsync_in;
      vs_d  = vsync_in;
      xp_d  = hs_edge ? 1'b0 : ~xp_q;
      if (vs_edge)      yp_d = 1'b0;
      else if (hs_edge) yp_d = ~yp_q;
      if (vs_edge && TEMPORAL) fp_d = ~fp_q;
      r1_d  = r_in;
      g1_d  = g_in;
      b1_d  = b_in;
      bl1_d = blank_in;
      hs1_d = hsync_in;
      vs1_d = vsync_in;
      t1_d  = dither_en ? bayer_t(yp_q, xp_q ^ fp_q) : 3'd0;
      r2_d  = r_dit;
      g2_d  = g_dit;
      b2_d  = b_dit;
      hs2_d = hs1_q;
      vs2_d = vs1_q;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      hs_q  <= HS_IDLE;
      vs_q  <= VS_IDLE;
      xp_q  <= 1'b0;
      yp_q  <= 1'b0;
      fp_q  <= 1'b0;
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
      bl1_q <= 1'b1;
      hs1_q <= HS_IDLE;
      vs1_q <= VS_IDLE;
      t1_q  <= '0;
      r2_q  <= '0;
      g2_q  <= '0;
      b2_q  <= '0;
      hs2_q <= HS_IDLE;
      vs2_q <= VS_IDLE;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      xp_q  <= xp_d;
      yp_q  <= yp_d;
      fp_q  <= fp_d;
      r1_q  <= r1_d;
      g1_q  <= g1_d;
      b1_q  <= b1_d;
      bl1_q <= bl1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      t1_q  <= t1_d;
      r2_q  <= r2_d;
      g2_q  <= g2_d;
      b2_q  <= b2_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
    end
  end

  assign r_out     = r2_q;
  assign g_out     = g2_q;
  assign b_out     = b2_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: tb/tb_rgb_dither_out.sv
// Bench for rgb_dither_out, TEMPORAL=1 and TEMPORAL=0 instances.
// Directed frames plus random stimulus against a pixel-level model.
module tb_rgb_dither_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pix_ce, blank_in;
  logic       hsync_in, vsync_in, dither_en;
  logic [5:0] r_in, g_in, b_in;

  logic [2:0] r1o, g1o, b1o, r0o, g0o, b0o;
  logic       hs1o, vs1o, hs0o, vs0o;

  rgb_dither_out dut1 (
    .clk_vga(clk), .reset(reset), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .blank_in(blank_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .dither_en(dither_en),
    .r_out(r1o), .g_out(g1o), .b_out(b1o),
    .hsync_out(hs1o), .vsync_out(vs1o)
  );

  rgb_dither_out #(.TEMPORAL(1'b0)) dut0 (
    .clk_vga(clk), .reset(reset), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .blank_in(blank_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .dither_en(dither_en),
    .r_out(r0o), .g_out(g0o), .b_out(b0o),
    .hsync_out(hs0o), .vsync_out(vs0o)
  );

  int total = 0;
  int bad = 0;

  localparam logic [10:0] IDLE = 11'b000_000_000_11;

  int bay [2][2] = '{'{0, 4}, '{6, 2}};
  int xp, yp, hprev, vprev;
  int fp [2];
  logic [10:0] stage_a [2];
  logic [10:0] exp_o [2];

  bit den_g;
  bit rnd_den;

  function automatic logic [2:0] chan(int c, int t, bit blk);
    int v;
    v = (c + t) / 8;
    if (v > 7) v = 7;
    if (blk) v = 0;
    return 3'(v);
  endfunction

  task automatic check(string tag, logic [10:0] obs,
                       logic [10:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h t=%0t",
             tag, obs, expv, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ce,
                      input bit blk, input bit hs,
                      input bit vs, input int r,
                      input int g, input int b);
    bit he, ve;
    int t;
    @(negedge clk);
    reset     = rst;
    pix_ce    = ce;
    blank_in  = blk;
    hsync_in  = hs;
    vsync_in  = vs;
    dither_en = den_g;
    r_in = 6'(r);
    g_in = 6'(g);
    b_in = 6'(b);
    @(posedge clk);
    if (rst) begin
      xp = 0; yp = 0; hprev = 1; vprev = 1;
      for (int k = 0; k < 2; k++) begin
        fp[k] = 0;
        stage_a[k] = IDLE;
        exp_o[k] = IDLE;
      end
    end else if (ce) begin
      he = (hs == 0) && (hprev == 1);
      ve = (vs == 0) && (vprev == 1);
      for (int k = 0; k < 2; k++) begin
        t = den_g ? bay[yp][xp ^ fp[k]] : 0;
        exp_o[k] = stage_a[k];
        stage_a[k] = {chan(r, t, blk), chan(g, t, blk),
                      chan(b, t, blk), hs, vs};
      end
      if (ve) begin
        yp = 0;
        fp[1] = fp[1] ^ 1;
      end else if (he) begin
        yp = yp ^ 1;
      end
      xp = he ? 0 : (xp ^ 1);
      hprev = hs;
      vprev = vs;
    end
    #1;
    check("temporal", {r1o, g1o, b1o, hs1o, vs1o}, exp_o[1]);
    check("static", {r0o, g0o, b0o, hs0o, vs0o}, exp_o[0]);
  endtask

  task automatic px(input bit hs, input bit vs,
                    input bit blk, input int r,
                    input int g, input int b, input int cm);
    int n;
    if (rnd_den) den_g = 1'($urandom);
    if (cm == 2) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++)
        step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 63), $urandom_range(0, 63),
             $urandom_range(0, 63));
    end
    step(0, 1, blk, hs, vs, r, g, b);
    if (cm == 1)
      step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 63));
  endtask

  task automatic line(input int npix, input bit vsl,
                      input int cm, input int cmode,
                      input int cval, input int hslen);
    int r, g, b;
    bit blk;
    for (int i = 0; i < hslen; i++)
      px(0, !vsl, 1, $urandom_range(0, 63),
         $urandom_range(0, 63), $urandom_range(0, 63), cm);
    for (int i = 0; i < npix; i++) begin
      r = cval; g = cval; b = cval; blk = 0;
      if (cmode != 0) begin
        r = $urandom_range(0, 63);
        g = $urandom_range(0, 63);
        b = $urandom_range(0, 63);
        blk = ($urandom_range(0, 7) == 0);
      end
      px(1, 1, blk, r, g, b, cm);
    end
  endtask

  task automatic frame(input int nlines, input int npix,
                       input int cm, input int cmode,
                       input int cval, input int hslen);
    for (int l = 0; l < nlines; l++)
      line(npix, l == 0, cm, cmode, cval, hslen);
    for (int i = 0; i < 3; i++)
      px(1, 1, 1, 0, 0, 0, cm);
  endtask

  initial begin
    den_g = 0;
    rnd_den = 0;
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom), 0, 0, 0, 63, 63, 63);
    check("reset_lit", {r1o, g1o, b1o, hs1o, vs1o},
          11'b000_000_000_11);

    for (int i = 0; i < 4; i++) px(1, 1, 0, 45, 45, 45, 0);
    check("trunc_lit", {8'd0, r1o}, 11'd5);

    den_g = 1;
    for (int i = 0; i < 4; i++) px(1, 1, 0, 45, 45, 45, 0);

    frame(2, 4, 0, 0, 63, 2);
    frame(2, 4, 0, 0, 63, 2);

    for (int f = 0; f < 3; f++) frame(2, 6, 0, 0, 4, 2);

    frame(2, 6, 1, 0, 4, 3);
    frame(2, 6, 1, 1, 0, 3);

    rnd_den = 1;
    for (int f = 0; f < 4; f++) frame(3, 8, 2, 1, 0, 2);
    rnd_den = 0;
    den_g = 1;

    for (int i = 0; i < 3; i++) px(0, 1, 0, 63, 63, 63, 0);
    step(1, 0, 0, 0, 1, 63, 63, 63);
    check("mid_rst_lit", {r1o, g1o, b1o, hs1o, vs1o},
          11'b000_000_000_11);
    for (int i = 0; i < 5; i++) px(1, 1, 0, 20, 20, 20, 0);
    frame(2, 6, 0, 0, 4, 2);
    frame(2, 6, 2, 1, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_dither_out.md
RGB_DITHER_OUT -- requirements
Module: rgb_dither_out

Interface
REQ-001 The block SHALL have parameter HSYNC_ACT_LOW, default 1, meaning hsync_in and hsync_out are active-low.
REQ-002 The block SHALL have parameter VSYNC_ACT_LOW, default 1, meaning vsync_in and vsync_out are active-low.
REQ-003 The block SHALL have parameter TEMPORAL, default 1, meaning the dither pattern alternates on every frame.
REQ-004 Port clk_vga  input  1  pixel clock; the block SHALL use this one clock only.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port pix_ce  input  1  pixel clock enable; the pipeline SHALL advance only when this is 1.
REQ-007 Port r_in, g_in, b_in  input  6 each  pixel colour from the video core.
REQ-008 Port blank_in  input  1  1 = pixel outside the active area.
REQ-009 Port hsync_in, vsync_in  input  1 each  raw syncs from the video core.
REQ-010 Port dither_en  input  1  0 = plain truncation; 1 = ordered dither.
REQ-011 Port r_out, g_out, b_out  output  3 each  colour to the 3-bit DAC pins.
REQ-012 Port hsync_out, vsync_out  output  1 each  syncs aligned with the colour outputs.

Function
REQ-013 Latency SHALL be exactly 2 pix_ce-qualified cycles from the inputs to every output.
- Colour, blank and both syncs SHALL pass through identical delay.
REQ-014 While pix_ce=0, all pipeline registers and counters SHALL hold their values.
REQ-015 Column parity xp SHALL toggle on every pix_ce cycle and clear to 0 on each active-going edge of hsync_in.
REQ-016 Row parity yp SHALL toggle on each active-going edge of hsync_in and clear to 0 on each active-going edge of vsync_in.
REQ-017 Frame parity fp SHALL toggle on each active-going edge of vsync_in when TEMPORAL=1, and SHALL be held at 0 otherwise.
REQ-018 Sync edges SHALL be detected from a registered copy of each sync input; the edge-detect register SHALL update only on pix_ce.
REQ-019 The dither threshold t (3 bits) SHALL come from a 2x2 Bayer table indexed by (yp, xp XOR fp):
- (0,0)=0, (0,1)=4, (1,0)=6, (1,1)=2.
REQ-020 Stage 1 SHALL register the colour, blank and syncs together with t.
REQ-021 Stage 2 SHALL compute, per channel, s = {1'b0, c} + t in 7 bits.
- Output = 7 when s > 63, otherwise s[5:3].
- The saturation SHALL prevent wrap-around, so that 63 + t always yields 7.
REQ-022 When dither_en=0, t SHALL be forced to 0, so that output = c[5:3].
REQ-023 When a pixel's stage-1 blank bit is 1, its colour outputs SHALL be 0 regardless of dither_en.
REQ-024 An active-going edge of hsync_in and an active-going edge of vsync_in in the same cycle SHALL apply both REQ-016 actions.
- yp SHALL clear, since the vsync clear takes priority.
- fp SHALL toggle.
REQ-025 Changing dither_en mid-frame SHALL take effect on the pixel sampled in that cycle; no other state SHALL be disturbed.

Reset
REQ-026 While reset=1 on a clk_vga edge, the following SHALL be cleared regardless of pix_ce:
- xp, yp and fp SHALL clear to 0.
- All pipeline colour registers SHALL clear to 0.
- Pipeline blank bits SHALL be set to 1.
REQ-027 During and after reset, until valid data reaches the output, the outputs SHALL be driven as follows:
- r_out, g_out and b_out SHALL be 0.
- hsync_out and vsync_out SHALL be at their inactive level (1 when the corresponding *_ACT_LOW = 1).
REQ-028 During reset, the sync edge-detect registers SHALL load their inactive level, so that no false edge is seen on release.
REQ-029 A reset asserted mid-line SHALL abort the line; the first line after release SHALL start with yp=0 and xp=0.

Structure
REQ-030 A shared package rgb_dither_pkg SHALL hold the Bayer table constants, IN_W=6, OUT_W=3 and the saturation limit.
REQ-031 A sub-module dither_ch SHALL implement one channel of the stage-2 add, saturate and blank logic, and SHALL be instantiated three times.
REQ-032 The parity counters, sync edge detection and pipeline control SHALL reside in rgb_dither_out.

Verification
REQ-033 Truncation check: dither_en=0, r_in=45 (101101), blank_in=0, pix_ce=1 -> r_out=5 two cycles later; with dither_en=1 and t=4, r_out=6.
REQ-034 Saturation check: dither_en=1, r_in=g_in=b_in=63 for a full 4x2 pixel area -> every output is 7, never 0.
REQ-035 Pattern check: dither_en=1, constant input 4, TEMPORAL=0 -> r_out row0 = 0,1,0,1…; row1 = 1,0,1,0…; identical pattern on the next frame.
REQ-036 Temporal check: same stimulus with TEMPORAL=1 -> frame 1 row0 = 1,0,1,0…; frame 2 returns to the frame-0 pattern.
REQ-037 Clock-enable and alignment check: pix_ce toggling 1,0,1,0 with hsync_in pulsed low for 3 enabled cycles -> hsync_out low for exactly 3 enabled cycles, delayed 2 enabled cycles, and colour still aligned.
REQ-038 Reset check: reset asserted mid-line while r_in=63 and hsync active -> outputs 0 and syncs inactive on the next edge; after release, no yp toggle occurs until a real hsync edge.
